// File: rtl/ysyx_24100006_pkg.sv
// Shared ID-stage definitions: Imm_Type selects, RV32I opcodes and decode-slot state encoding.
package ysyx_24100006_pkg;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_J    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } idu_state_e;

endpackage

// File: rtl/ysyx_24100006_imm_type_dec.sv
// Combinational opcode decoder: selects the immediate format and flags opcodes outside RV32I.
module ysyx_24100006_imm_type_dec
  import ysyx_24100006_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_type,
  output logic       illegal
);

  always_comb begin
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC:                                    imm_type = IMM_U;
      OPC_JAL:                                               imm_type = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM, OPC_FENCE: imm_type = IMM_I;
      OPC_STORE:                                             imm_type = IMM_S;
      OPC_BRANCH:                                            imm_type = IMM_B;
      OPC_OP:                                                imm_type = IMM_NONE;
      default:                                               illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_24100006_idu_ctrl.sv
// ID-stage single-slot sequencer between IFU and EXU, with flush and a saturating stall counter.
// Defining YSYX_24100006_IDU_ILLEGAL_EN adds the registered out_illegal flag.
module ysyx_24100006_idu_ctrl
  import ysyx_24100006_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_inst,
  input  logic [XLEN-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_inst,
  output logic [XLEN-1:0]        out_pc,
  output logic [2:0]             imm_type,
  output logic [STALL_CNT_W-1:0] stall_cnt
`ifdef YSYX_24100006_IDU_ILLEGAL_EN
  ,
  output logic                   out_illegal
`endif
);

  idu_state_e             state_q, state_d;
  logic [XLEN-1:0]        inst_q, pc_q;
  logic [2:0]             imm_type_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [2:0]             dec_imm_type;
  logic                   dec_illegal;
  logic                   accept, drain, stall;

  ysyx_24100006_imm_type_dec u_imm_type_dec (
    .opcode   (in_inst[6:0]),
    .imm_type (dec_imm_type),
    .illegal  (dec_illegal)
  );

  // in_ready deliberately ignores in_valid so IFU can use it without a combinational loop.
  assign in_ready = !flush && ((state_q == ST_EMPTY) || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = (state_q == ST_FULL) && out_ready && !accept;
  assign stall    = (state_q == ST_FULL) && !out_ready;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = ST_FULL;
    end else if (drain) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Payload is only rewritten on accept; after flush/drain it is stale and qualified by out_valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      inst_q      <= '0;
      pc_q        <= '0;
      imm_type_q  <= IMM_NONE;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      if (accept) begin
        inst_q     <= in_inst;
        pc_q       <= in_pc;
        imm_type_q <= dec_imm_type;
      end
    end
  end

`ifdef YSYX_24100006_IDU_ILLEGAL_EN
  logic illegal_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (accept) begin
      illegal_q <= dec_illegal;
    end
  end

  assign out_illegal = illegal_q;
`else
  logic unused_dec_illegal;
  assign unused_dec_illegal = dec_illegal;
`endif

  assign out_valid = (state_q == ST_FULL);
  assign out_inst  = inst_q;
  assign out_pc    = pc_q;
  assign imm_type  = imm_type_q;
  assign stall_cnt = stall_cnt_q;

endmodule
